mul_div_sequencer: RTL and testbench
====================================

MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 Parameter XLEN, default 32: operand and result width; iteration count equals XLEN.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  core requests an M-extension operation; held high by the core while the instruction is current.
REQ-005 op_i  input  2  00 MUL (low product), 01 MULHU (high unsigned product), 10 DIVU, 11 REMU; sampled only on accept.
REQ-006 a_i  input  XLEN  operand rs1; sampled only on accept.
REQ-007 b_i  input  XLEN  operand rs2; sampled only on accept.
REQ-008 stall_o  output  1  freezes PC and register-file write while high.
REQ-009 busy_o  output  1  high in RUN.
REQ-010 done_o  output  1  one-cycle pulse; result_o valid and write-back permitted.
REQ-011 result_o  output  XLEN  selected result; holds last value outside DONE.

Function
REQ-012 FSM states: IDLE, RUN, DONE.
REQ-013 Accept: IDLE with start_i=1 latches op_i, a_i, b_i, loads iteration counter with XLEN-1, goes to RUN.
REQ-014 DIVU/REMU with b_i=0 at accept: skip RUN, go to DONE next cycle; DIVU result all ones, REMU result a_i.
REQ-015 RUN: one radix-2 step per cycle (shift-add for multiply, restoring shift-subtract for divide); counter decrements each cycle; counter=0 step moves to DONE; exactly XLEN RUN cycles.
REQ-016 Multiply: 2*XLEN-bit unsigned accumulator; MUL returns bits [XLEN-1:0], MULHU bits [2*XLEN-1:XLEN]; wrap-around modulo 2^(2*XLEN).
REQ-017 Divide: unsigned quotient and remainder; DIVU returns quotient, REMU remainder.
REQ-018 DONE: done_o=1 and result_o updated for exactly one cycle; unconditional move to IDLE; start_i ignored in DONE.
REQ-019 start_i ignored in RUN; operands are not re-sampled.
REQ-020 stall_o = (IDLE and start_i) or RUN; low in DONE so the core retires the instruction that cycle.
REQ-021 Latency: accept at cycle 0, done_o at cycle XLEN+1 (33 at default); cycle 1 on divide-by-zero.
REQ-022 Back-to-back: start_i high in IDLE the cycle after DONE is a new accept; no idle bubble is required.
REQ-023 start_i deasserted mid-RUN: operation still completes and pulses done_o.

Reset
REQ-024 reset low: state IDLE, counter 0, accumulators 0, result_o 0, stall_o 0, busy_o 0, done_o 0; takes effect immediately regardless of clk.
REQ-025 Reset during RUN aborts the operation; no done_o pulse is produced for it.
REQ-026 Release of reset with start_i high: accept on the first rising edge after release.

Structure
REQ-027 Op encodings (MUL, MULHU, DIVU, REMU) and FSM state encodings live in a shared package also used by Control.
REQ-028 One sub-module, mul_div_datapath: holds the accumulator/shift registers and one step per enable; the sequencer keeps the FSM and counter.
REQ-029 No combinational path from start_i to result_o; stall_o is the only combinational output.

Verification
REQ-030 MUL a=7, b=6, start at cycle 0 -> stall_o high cycles 0-32, done_o at cycle 33, result_o=42.
REQ-031 MULHU a=b=0xFFFFFFFF -> result_o=0xFFFFFFFE at done; MUL with the same operands -> 0x00000001.
REQ-032 DIVU 100/7 -> 14; REMU 100/7 -> 2; both after 33 cycles.
REQ-033 DIVU 5/0 -> done_o at cycle 1, result_o=0xFFFFFFFF; REMU 5/0 -> 5.
REQ-034 reset asserted at RUN cycle 10 -> all outputs 0 immediately, no done_o; new MUL 3*4 after release -> 12.
REQ-035 start_i held high across DONE then new op 9/3 DIVU -> exactly one done_o per op, second result 3, no double accept.

Source files
------------

// File: rtl/mul_div_sequencer_pkg.sv
// Shared encodings for the M-extension multiply/divide sequencer.
// Both the controller and the datapath import these types.
package mul_div_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // The upper opcode bit selects the divider family (DIVU/REMU).
  function automatic logic is_div(op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/mul_div_sequencer_if.sv
// Core <-> sequencer bundle. start_i is a level request held by the core while
// the instruction is current; done_o is a one-cycle completion pulse.
interface mul_div_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [1:0]      op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/mul_div_datapath.sv
// Radix-2 shift-add multiplier / restoring divider sharing one 2*XLEN accumulator.
// res_next is the result as it will look after the current edge.
module mul_div_datapath
  import mul_div_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  op_t             op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] res_next
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   hi, lo;
  op_t               op_q, op_d;
  logic              div0_q, div0_d;
  logic [XLEN:0]     mul_sum, div_tmp, div_diff;

  assign hi = acc_q[2*XLEN-1:XLEN];
  assign lo = acc_q[XLEN-1:0];

  // Multiply: hi accumulates, lo holds the multiplier and shifts right.
  // Divide: hi is the partial remainder, lo the dividend shifting into quotient.
  always_comb begin
    mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd_q} : '0);
    div_tmp  = {hi, lo[XLEN-1]};
    div_diff = div_tmp - {1'b0, opnd_q};
    acc_d    = acc_q;
    op_d     = op_q;
    div0_d   = div0_q;
    if (load) begin
      op_d   = op;
      div0_d = is_div(op) && (b == '0);
      acc_d  = is_div(op) ? {{XLEN{1'b0}}, a} : {{XLEN{1'b0}}, b};
    end else if (step) begin
      if (is_div(op_q)) begin
        if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], lo[XLEN-2:0], 1'b1};
        else                 acc_d = {div_tmp[XLEN-1:0],  lo[XLEN-2:0], 1'b0};
      end else begin
        acc_d = {mul_sum, lo[XLEN-1:1]};
      end
    end
  end

  // On a zero divisor lo still holds the dividend, which is the REMU answer.
  always_comb begin
    case (op_d)
      OP_MUL:   res_next = acc_d[XLEN-1:0];
      OP_MULHU: res_next = acc_d[2*XLEN-1:XLEN];
      OP_DIVU:  res_next = div0_d ? '1 : acc_d[XLEN-1:0];
      default:  res_next = div0_d ? acc_d[XLEN-1:0] : acc_d[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      opnd_q <= '0;
      op_q   <= OP_MUL;
      div0_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      op_q   <= op_d;
      div0_q <= div0_d;
      if (load) opnd_q <= is_div(op) ? b : a;
    end
  end

endmodule

// File: rtl/mul_div_sequencer.sv
// Multi-cycle M-extension sequencer: IDLE/RUN/DONE control, iteration counter
// and registered result around the shared mul/div datapath.
module mul_div_sequencer
  import mul_div_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  mul_div_sequencer_if.slave   bus,
  output state_t               state_dbg
);

  localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            load, step;
  logic            div_by_zero;
  logic [XLEN-1:0] res_next;
  logic [XLEN-1:0] result_q;
  op_t             op_in;

  assign op_in       = op_t'(bus.op_i);
  assign div_by_zero = is_div(op_in) && (bus.b_i == '0);
  assign state_dbg   = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start_i) state_d = div_by_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (cnt_q == '0) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // stall is the only output allowed to follow start_i combinationally.
  always_comb begin
    load        = (state_q == ST_IDLE) && bus.start_i;
    step        = (state_q == ST_RUN);
    bus.busy_o  = step;
    bus.done_o  = (state_q == ST_DONE);
    bus.stall_o = reset && (load || step);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(XLEN - 1);
    end else if (step) begin
      cnt_q <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    end
  end

  // Captured on the edge entering DONE, then held until the next completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                        result_q <= '0;
    else if (state_d == ST_DONE && state_q != ST_DONE) result_q <= res_next;
  end

  assign bus.result_o = result_q;

  mul_div_datapath #(.XLEN(XLEN)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .op       (op_in),
    .a        (bus.a_i),
    .b        (bus.b_i),
    .res_next (res_next)
  );

endmodule

// File: tb/tb_mul_div_sequencer.sv
// Directed bench for mul_div_sequencer: latency, results, stall/busy/done shape,
// divide-by-zero, reset abort and back-to-back operation.
module tb_mul_div_sequencer;
  import mul_div_sequencer_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;
  int     checks;
  int     errors;
  int     done_cnt;
  int     exp_done;

  mul_div_sequencer_if #(.XLEN(32)) bus ();

  mul_div_sequencer #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done_o === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: called just after a rising edge with the DUT in IDLE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string tag,
                       input bit keep, input bit drop_mid);
    int   lat;
    logic [31:0] res;
    bit   stall_bad, busy_bad;
    logic stall_done;
    lat = -1; res = '0; stall_bad = 0; busy_bad = 0; stall_done = 1'b0;
    bus.start_i = 1'b1; bus.op_i = op; bus.a_i = a; bus.b_i = b;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) begin
        lat = c; res = bus.result_o; stall_done = bus.stall_o;
        break;
      end
      if (bus.stall_o !== 1'b1) stall_bad = 1;
      if (bus.busy_o !== (c > 0)) busy_bad = 1;
      @(posedge clk); #1;
      if (c == 3) begin
        bus.a_i = $urandom; bus.b_i = $urandom; bus.op_i = 2'($urandom_range(0, 3));
      end
      if (drop_mid && c == 5) bus.start_i = 1'b0;
    end
    exp_done++;
    if (!keep) bus.start_i = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, res, exp);
    check({tag, "_stall_shape"}, {31'b0, stall_bad}, 32'd0);
    check({tag, "_busy_shape"}, {31'b0, busy_bad}, 32'd0);
    check({tag, "_stall_in_done"}, {31'b0, stall_done}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; exp_done = 0;
    reset = 1'b0;
    bus.start_i = 1'b0; bus.op_i = 2'b00; bus.a_i = '0; bus.b_i = '0;
    #2;
    check("reset_state", {30'b0, state_dbg}, {30'b0, ST_IDLE});
    check("reset_outputs", {29'b0, bus.stall_o, bus.busy_o, bus.done_o}, 32'd0);
    check("reset_result", bus.result_o, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    do_op(2'b00, 32'd7,        32'd6,        32'd42,         33, "mul_7x6",      0, 0);
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,   33, "mulhu_max",    0, 0);
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   33, "mul_max",      0, 0);
    do_op(2'b10, 32'd100,      32'd7,        32'd14,         33, "divu_100_7",   0, 0);
    do_op(2'b11, 32'd100,      32'd7,        32'd2,          33, "remu_100_7",   0, 0);
    do_op(2'b10, 32'd5,        32'd0,        32'hFFFFFFFF,   1,  "divu_5_0",     0, 0);
    do_op(2'b11, 32'd5,        32'd0,        32'd5,          1,  "remu_5_0",     0, 0);
    do_op(2'b11, 32'hFFFFFFFF, 32'h10,       32'hF,          33, "remu_drop",    0, 1);
    do_op(2'b01, 32'h80000000, 32'd2,        32'd1,          33, "mulhu_carry",  0, 0);
    do_op(2'b10, 32'd7,        32'd100,      32'd0,          33, "divu_small",   0, 0);
    do_op(2'b10, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF,   33, "divu_by_one",  0, 0);

    // Abort an operation in RUN cycle 10 with start still requested.
    bus.start_i = 1'b1; bus.op_i = 2'b00; bus.a_i = 32'h1234; bus.b_i = 32'h5678;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'b0, bus.busy_o}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_outputs", {29'b0, bus.stall_o, bus.busy_o, bus.done_o}, 32'd0);
    check("abort_result", bus.result_o, 32'd0);
    check("abort_state", {30'b0, state_dbg}, {30'b0, ST_IDLE});
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(exp_done));
    @(posedge clk); #1;
    reset = 1'b1;
    do_op(2'b00, 32'd3,        32'd4,        32'd12,         33, "mul_3x4",      1, 0);
    do_op(2'b10, 32'd9,        32'd3,        32'd3,          33, "divu_9_3_b2b", 0, 0);

    repeat (4) @(negedge clk);
    check("idle_done_low", {31'b0, bus.done_o}, 32'd0);
    check("idle_result_hold", bus.result_o, 32'd3);
    check("done_pulse_count", 32'(done_cnt), 32'(exp_done));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
